// File: rtl/simd_mac_unit.sv
// simd_mac_unit: packed-SIMD arithmetic unit (lane add, half-width lane
// multiplies, dot product, multiply-accumulate) with a time-multiplexed bank
// of MULS multipliers and valid/ready handshakes on both sides.
//
// Build option: define SIMD_MAC_SAT_EN for saturating PVADD/PVMAC and the
// extra sat output. Without it all arithmetic wraps and there is no sat port.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// MUL   | multiplier beats, MULS lane products per cycle
// FIN   | form result, update accumulator, raise out_valid
// HOLD  | present result until out_ready
module simd_mac_unit #(
  parameter  int LANE_W = 8,
  parameter  int LANES  = 4,
  parameter  int MULS   = 2,
  localparam int XLEN   = LANE_W * LANES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
`ifdef SIMD_MAC_SAT_EN
  ,
  output logic            sat
`endif
);

  localparam int PW         = 2 * LANE_W;
  localparam int NBEAT_FULL = LANES / MULS;
  localparam int NBEAT_HALF = (LANES / 2) / MULS;
  localparam int BW         = $clog2(NBEAT_FULL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_MUL_LO = 3'b001,
    OP_DOT    = 3'b010,
    OP_MUL_HI = 3'b011,
    OP_MAC    = 3'b100,
    OP_ACCRD  = 3'b101,
    OP_ACCCLR = 3'b110,
    OP_RSVD   = 3'b111
  } op_t;

  state_t              state_q, state_nxt;
  op_t                 op_q;
  logic                sgn_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic [BW-1:0]       beat_q, beat_last;
  logic [LANES*PW-1:0] prod_q, prod_nxt;
  logic [XLEN-1:0]     acc_q, acc_nxt;
  logic [XLEN-1:0]     result_q, fin_result;
  logic                out_valid_q, illegal_q, fin_illegal;
  logic                accept;
  int                  lane_base;
  logic [XLEN-1:0]     dot;
  logic [XLEN-1:0]     add_res;
  logic [XLEN-1:0]     mac_sum;
  logic [LANE_W-1:0]   la, lb;

`ifdef SIMD_MAC_SAT_EN
  localparam logic [LANE_W-1:0] LANE_SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_SMIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [XLEN-1:0]   ACC_SMAX  = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0]   ACC_SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [LANE_W:0] lane_sum;
  logic [XLEN:0]   mac_wide;
  logic            add_sat, mac_sat, fin_sat, sat_q;
`endif

  // Lane value widened to a product operand, sign- or zero-extended.
  function automatic logic [PW-1:0] ext_lane(input logic [LANE_W-1:0] v, input logic s);
    logic [PW-1:0] r;
    if (s) r = PW'($signed(v));
    else   r = PW'(v);
    return r;
  endfunction

  // Lane product widened to the full word for summation.
  function automatic logic [XLEN-1:0] ext_prod(input logic [PW-1:0] v, input logic s);
    logic [XLEN-1:0] r;
    if (s) r = XLEN'($signed(v));
    else   r = XLEN'(v);
    return r;
  endfunction

  function automatic logic needs_mul(input logic [2:0] o);
    return (o == OP_MUL_LO) || (o == OP_MUL_HI) || (o == OP_DOT) || (o == OP_MAC);
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
`ifdef SIMD_MAC_SAT_EN
  assign sat       = sat_q;
`endif

  assign beat_last = ((op_q == OP_DOT) || (op_q == OP_MAC)) ? BW'(NBEAT_FULL - 1)
                                                           : BW'(NBEAT_HALF - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_nxt = needs_mul(op) ? S_MUL : S_FIN;
      S_MUL:  if (beat_q == beat_last) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_HOLD;
      S_HOLD: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One multiplier beat: MULS lane products written into their slots.
  always_comb begin
    prod_nxt  = prod_q;
    lane_base = (op_q == OP_MUL_HI) ? LANES / 2 : 0;
    for (int j = 0; j < MULS; j++) begin
      prod_nxt[(int'(beat_q) * MULS + j) * PW +: PW] =
        ext_lane(a_q[(lane_base + int'(beat_q) * MULS + j) * LANE_W +: LANE_W], sgn_q) *
        ext_lane(b_q[(lane_base + int'(beat_q) * MULS + j) * LANE_W +: LANE_W], sgn_q);
    end
  end

  // Dot product: every stored lane product extended and summed.
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + ext_prod(prod_q[i * PW +: PW], sgn_q);
    end
  end

  // Lane-wise add, clamped per lane when saturation is built in.
  always_comb begin
    add_res = '0;
    la      = '0;
    lb      = '0;
`ifdef SIMD_MAC_SAT_EN
    add_sat  = 1'b0;
    lane_sum = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      la = a_q[i * LANE_W +: LANE_W];
      lb = b_q[i * LANE_W +: LANE_W];
`ifdef SIMD_MAC_SAT_EN
      lane_sum = {1'b0, la} + {1'b0, lb};
      add_res[i * LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
      if (sgn_q) begin
        if ((la[LANE_W-1] == lb[LANE_W-1]) && (lane_sum[LANE_W-1] != la[LANE_W-1])) begin
          add_res[i * LANE_W +: LANE_W] = la[LANE_W-1] ? LANE_SMIN : LANE_SMAX;
          add_sat = 1'b1;
        end
      end else if (lane_sum[LANE_W]) begin
        add_res[i * LANE_W +: LANE_W] = '1;
        add_sat = 1'b1;
      end
`else
      add_res[i * LANE_W +: LANE_W] = la + lb;
`endif
    end
  end

  // Accumulator plus dot product, clamped to the word range when saturating.
  always_comb begin
`ifdef SIMD_MAC_SAT_EN
    mac_wide = {1'b0, acc_q} + {1'b0, dot};
    mac_sum  = mac_wide[XLEN-1:0];
    mac_sat  = 1'b0;
    if (sgn_q) begin
      if ((acc_q[XLEN-1] == dot[XLEN-1]) && (mac_wide[XLEN-1] != acc_q[XLEN-1])) begin
        mac_sum = acc_q[XLEN-1] ? ACC_SMIN : ACC_SMAX;
        mac_sat = 1'b1;
      end
    end else if (mac_wide[XLEN]) begin
      mac_sum = '1;
      mac_sat = 1'b1;
    end
`else
    mac_sum = acc_q + dot;
`endif
  end

  // Result selection and accumulator update for the FIN cycle.
  always_comb begin
    fin_result  = '0;
    fin_illegal = 1'b0;
    acc_nxt     = acc_q;
`ifdef SIMD_MAC_SAT_EN
    fin_sat     = 1'b0;
`endif
    case (op_q)
      OP_ADD: begin
        fin_result = add_res;
`ifdef SIMD_MAC_SAT_EN
        fin_sat    = add_sat;
`endif
      end
      OP_MUL_LO, OP_MUL_HI: fin_result = prod_q[XLEN-1:0];
      OP_DOT:    fin_result = dot;
      OP_MAC: begin
        fin_result = mac_sum;
        acc_nxt    = mac_sum;
`ifdef SIMD_MAC_SAT_EN
        fin_sat    = mac_sat;
`endif
      end
      OP_ACCRD:  fin_result = acc_q;
      OP_ACCCLR: begin
        fin_result = acc_q;
        acc_nxt    = '0;
      end
      default:   fin_illegal = 1'b1;
    endcase
  end

  // Operand capture, beat counting, product bank, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_ADD;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      beat_q      <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SIMD_MAC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q   <= op_t'(op);
        sgn_q  <= sgn;
        a_q    <= a;
        b_q    <= b;
        beat_q <= '0;
      end else if (state_q == S_MUL) begin
        beat_q <= beat_q + 1'b1;
      end

      if (state_q == S_MUL) prod_q <= prod_nxt;

      if (state_q == S_FIN) begin
        acc_q       <= acc_nxt;
        result_q    <= fin_result;
        illegal_q   <= fin_illegal;
        out_valid_q <= 1'b1;
`ifdef SIMD_MAC_SAT_EN
        sat_q       <= fin_sat;
`endif
      end else if ((state_q == S_HOLD) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simd_mac_unit.sv
// Self-checking bench for simd_mac_unit (default geometry: 4 lanes x 8 bits,
// 2 multipliers). Vector table plus hand-written backpressure and reset
// sequences; expected results go through a scoreboard queue.
module tb_simd_mac_unit;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_MUL_LO = 3'b001;
  localparam logic [2:0] OP_DOT    = 3'b010;
  localparam logic [2:0] OP_MUL_HI = 3'b011;
  localparam logic [2:0] OP_MAC    = 3'b100;
  localparam logic [2:0] OP_ACCRD  = 3'b101;
  localparam logic [2:0] OP_ACCCLR = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

`ifdef SIMD_MAC_SAT_EN
  localparam logic [31:0] ADD_S_EXP = 32'h7F020080;
  localparam logic [31:0] ADD_U_EXP = 32'hFF203040;
  localparam logic        ADD_SAT   = 1'b1;
`else
  localparam logic [31:0] ADD_S_EXP = 32'h80020000;
  localparam logic [31:0] ADD_U_EXP = 32'h00203040;
  localparam logic        ADD_SAT   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        sgn;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
`ifdef SIMD_MAC_SAT_EN
  logic        sat;
`endif

  typedef struct {
    logic [2:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    logic        sat;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic        sat;
  } exp_t;

  localparam int NV = 18;
  vec_t vecs[NV];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  simd_mac_unit #(.LANE_W(8), .LANES(4), .MULS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sgn       (sgn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
`ifdef SIMD_MAC_SAT_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // Pops the scoreboard entry for the result currently on the outputs.
  task automatic check_output(input string nm);
    exp_t e;
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({nm, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      if (out_valid) begin
        chk({nm, "_result"}, result, e.res);
        chk({nm, "_illegal"}, 32'(illegal), 32'(e.ill));
`ifdef SIMD_MAC_SAT_EN
        chk({nm, "_sat"}, 32'(sat), 32'(e.sat));
`endif
      end
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Issue one request with out_ready high; inputs are scrambled after accept.
  task automatic issue(input string nm, input logic [2:0] o, input logic s,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic ei, input logic es,
                       input int lat);
    int cyc;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    op = o; sgn = s; a = av; b = bv; in_valid = 1'b1;
    sb.push_back('{res: er, ill: ei, sat: es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a   = $urandom;
    b   = $urandom;
    sgn = ~s;
    op  = 3'($urandom);
    wait_out(cyc);
    check_output(nm);
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{OP_ADD,    1'b1, 32'h7F01FF80, 32'h01010180, ADD_S_EXP,    1'b0, ADD_SAT, 1};
    vecs[1]  = '{OP_MUL_LO, 1'b1, 32'h0000FF03, 32'h00000205, 32'hFFFE000F, 1'b0, 1'b0,    2};
    vecs[2]  = '{OP_MUL_LO, 1'b0, 32'h0000FF03, 32'h00000205, 32'h01FE000F, 1'b0, 1'b0,    2};
    vecs[3]  = '{OP_MUL_HI, 1'b0, 32'h0302AAAA, 32'h04055555, 32'h000C000A, 1'b0, 1'b0,    2};
    vecs[4]  = '{OP_DOT,    1'b0, 32'h01020304, 32'h01010101, 32'h0000000A, 1'b0, 1'b0,    3};
    vecs[5]  = '{OP_DOT,    1'b1, 32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFC, 1'b0, 1'b0,    3};
    vecs[6]  = '{OP_DOT,    1'b0, 32'hFFFFFFFF, 32'h01010101, 32'h000003FC, 1'b0, 1'b0,    3};
    vecs[7]  = '{OP_ACCCLR, 1'b0, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 1'b0,    1};
    vecs[8]  = '{OP_MAC,    1'b0, 32'h01020304, 32'h01010101, 32'h0000000A, 1'b0, 1'b0,    3};
    vecs[9]  = '{OP_MAC,    1'b0, 32'h01020304, 32'h01010101, 32'h00000014, 1'b0, 1'b0,    3};
    vecs[10] = '{OP_ACCRD,  1'b0, 32'h0,        32'h0,        32'h00000014, 1'b0, 1'b0,    1};
    vecs[11] = '{OP_ACCCLR, 1'b0, 32'h0,        32'h0,        32'h00000014, 1'b0, 1'b0,    1};
    vecs[12] = '{OP_ACCRD,  1'b0, 32'h0,        32'h0,        32'h00000000, 1'b0, 1'b0,    1};
    vecs[13] = '{OP_MAC,    1'b1, 32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFC, 1'b0, 1'b0,    3};
    vecs[14] = '{OP_RSVD,   1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0,    1};
    vecs[15] = '{OP_ACCRD,  1'b0, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b0, 1'b0,    1};
    vecs[16] = '{OP_ADD,    1'b0, 32'hFF102030, 32'h01101010, ADD_U_EXP,    1'b0, ADD_SAT, 1};
    vecs[17] = '{OP_ACCCLR, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b0, 1'b0,    1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'b000; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_result",    result,         32'd0);
    chk("reset_illegal",   32'(illegal),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue($sformatf("v%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].ill, vecs[i].sat, vecs[i].lat);
    end

    // Backpressure: result held for 5 cycles, a pulsed request is refused.
    out_ready = 1'b0;
    op = OP_DOT; sgn = 1'b0; a = 32'h01020304; b = 32'h01010101; in_valid = 1'b1;
    sb.push_back('{res: 32'h0000000A, ill: 1'b0, sat: 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    wait_out(cyc);
    check_output("bp");
    chk("bp_latency", 32'(cyc), 32'd3);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        op = OP_ADD; a = 32'h01010101; b = 32'h01010101; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("bp_hold%0d_valid", k),  32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result", k), result,         32'h0000000A);
      chk($sformatf("bp_hold%0d_ready", k),  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready),  32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_no_extra%0d", k), 32'(out_valid), 32'd0);
    end

    // Reset in MUL beat 1 of a PVMAC: aborted, never presented, acc cleared.
    issue("pre_rst_mac", OP_MAC, 1'b0, 32'h01020304, 32'h01010101,
          32'h0000000A, 1'b0, 1'b0, 3);
    op = OP_MAC; sgn = 1'b0; a = 32'h01020304; b = 32'h01010101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_quiet%0d", k), 32'(out_valid), 32'd0);
    end
    issue("rst_accrd", OP_ACCRD, 1'b0, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
